// File: rtl/cp0_tlb_regs_if.sv
// Pipeline-side bundle of cp0_tlb_regs: CP0 register access, TLB instruction
// handshake and TLB exception reporting.
interface cp0_tlb_regs_if;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] mtc0_wdata;
    logic [31:0] mfc0_rdata;
    logic        tlb_req;
    logic [2:0]  tlb_op;
    logic        tlb_busy;
    logic        tlb_done;
    logic        exc_tlb_valid;
    logic [31:0] exc_vaddr;

    modport master (
        output mtc0_we, cp0_addr, mtc0_wdata, tlb_req, tlb_op, exc_tlb_valid, exc_vaddr,
        input  mfc0_rdata, tlb_busy, tlb_done
    );

    modport slave (
        input  mtc0_we, cp0_addr, mtc0_wdata, tlb_req, tlb_op, exc_tlb_valid, exc_vaddr,
        output mfc0_rdata, tlb_busy, tlb_done
    );
endinterface

// File: rtl/cp0_tlb_regs.sv
// CP0 TLB management registers and TLBR/TLBWI/TLBWR/TLBP sequencer feeding the MMU.
// Optional ASID storage in EntryHi[7:0] is enabled by defining CP0_TLB_ASID_EN.
module cp0_tlb_regs #(
    parameter int TLB_entry_num        = 16,
    parameter int Entry_id_width       = 4,
    parameter int in_tlb_config_width  = 160,
    parameter int out_tlb_config_width = 142
) (
    input  logic                            clk,
    input  logic                            rst,
    cp0_tlb_regs_if.slave                   bus,
    input  logic                            tlbp_hit,
    input  logic [in_tlb_config_width-1:0]  in_tlb_config,
    output logic [out_tlb_config_width-1:0] out_tlb_config,
    output logic [2:0]                      op_type
);

    localparam logic [Entry_id_width-1:0] RANDOM_TOP = Entry_id_width'(TLB_entry_num - 1);
    localparam logic [Entry_id_width-1:0] ID_ONE     = Entry_id_width'(1);

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_TLBR = 3'b001;
    localparam logic [2:0] OP_TLBP = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic [2:0]                op_type_r;
    logic                      busy_r;
    logic                      done_r;

    logic [18:0]               hi_vpn2_r;
    logic [29:0]               lo0_r;
    logic [29:0]               lo1_r;
    logic                      index_p_r;
    logic [Entry_id_width-1:0] index_r;
    logic [Entry_id_width-1:0] random_r;
    logic [Entry_id_width-1:0] random_nxt_s;
    logic [Entry_id_width-1:0] wired_r;
    logic [8:0]                ctx_base_r;
    logic [18:0]               ctx_badvpn2_r;
    logic [31:0]               badvaddr_r;
`ifdef CP0_TLB_ASID_EN
    logic [7:0]                asid_r;
`endif

    logic [31:0] entry_hi_s;
    logic [31:0] rdata_s;
    logic        wr_s;
    logic        wr_index_s;
    logic        wr_lo0_s;
    logic        wr_lo1_s;
    logic        wr_ctx_s;
    logic        wr_wired_s;
    logic        wr_hi_s;
    logic        tlbr_cap_s;
    logic        tlbp_cap_s;
    logic        unused_s;

    function automatic logic op_is_legal(input logic [2:0] op);
        case (op)
            3'b001, 3'b010, 3'b011, 3'b100: op_is_legal = 1'b1;
            default:                        op_is_legal = 1'b0;
        endcase
    endfunction

    assign wr_s       = bus.mtc0_we && !busy_r;
    assign wr_index_s = wr_s && (bus.cp0_addr == 5'd0);
    assign wr_lo0_s   = wr_s && (bus.cp0_addr == 5'd2);
    assign wr_lo1_s   = wr_s && (bus.cp0_addr == 5'd3);
    assign wr_ctx_s   = wr_s && (bus.cp0_addr == 5'd4);
    assign wr_wired_s = wr_s && (bus.cp0_addr == 5'd6);
    assign wr_hi_s    = wr_s && (bus.cp0_addr == 5'd10);

    assign tlbr_cap_s = (state_r == ST_ISSUE) && (op_type_r == OP_TLBR);
    assign tlbp_cap_s = (state_r == ST_ISSUE) && (op_type_r == OP_TLBP);

    assign op_type      = op_type_r;
    assign bus.tlb_busy = busy_r;
    assign bus.tlb_done = done_r;

    // Next-state logic of the TLB instruction sequencer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.tlb_req && op_is_legal(bus.tlb_op)) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_DONE;
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Sequencer state and its registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            op_type_r <= OP_NONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            op_type_r <= (state_nxt_s == ST_ISSUE) ? bus.tlb_op : OP_NONE;
            busy_r    <= (state_nxt_s != ST_IDLE);
            done_r    <= (state_nxt_s == ST_DONE);
        end
    end

    // Random counts down from the top to Wired, frozen while an op is in flight
    always_comb begin
        random_nxt_s = random_r;
        if (wr_wired_s) begin
            random_nxt_s = RANDOM_TOP;
        end else if (state_r != ST_IDLE) begin
            random_nxt_s = random_r;
        end else if ((wired_r >= RANDOM_TOP) || (random_r == wired_r)) begin
            random_nxt_s = RANDOM_TOP;
        end else begin
            random_nxt_s = random_r - ID_ONE;
        end
    end

    // Architectural TLB registers: mtc0 writes, TLBR/TLBP capture, exception latching
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_vpn2_r     <= 19'd0;
            lo0_r         <= 30'd0;
            lo1_r         <= 30'd0;
            index_p_r     <= 1'b0;
            index_r       <= '0;
            random_r      <= RANDOM_TOP;
            wired_r       <= '0;
            ctx_base_r    <= 9'd0;
            ctx_badvpn2_r <= 19'd0;
            badvaddr_r    <= 32'd0;
        end else begin
            random_r <= random_nxt_s;

            if (bus.exc_tlb_valid) begin
                hi_vpn2_r <= bus.exc_vaddr[31:13];
            end else if (tlbr_cap_s) begin
                hi_vpn2_r <= in_tlb_config[31:13];
            end else if (wr_hi_s) begin
                hi_vpn2_r <= bus.mtc0_wdata[31:13];
            end else begin
                hi_vpn2_r <= hi_vpn2_r;
            end

            if (tlbr_cap_s) begin
                lo0_r <= in_tlb_config[61:32];
                lo1_r <= in_tlb_config[93:64];
            end else begin
                lo0_r <= wr_lo0_s ? bus.mtc0_wdata[29:0] : lo0_r;
                lo1_r <= wr_lo1_s ? bus.mtc0_wdata[29:0] : lo1_r;
            end

            // A probe miss sets P but keeps the previous index bits
            if (tlbp_cap_s) begin
                index_p_r <= ~tlbp_hit;
                if (tlbp_hit) begin
                    index_r <= in_tlb_config[96 +: Entry_id_width];
                end else begin
                    index_r <= index_r;
                end
            end else if (wr_index_s) begin
                index_r <= bus.mtc0_wdata[Entry_id_width-1:0];
            end else begin
                index_r <= index_r;
            end

            wired_r    <= wr_wired_s ? bus.mtc0_wdata[Entry_id_width-1:0] : wired_r;
            ctx_base_r <= wr_ctx_s ? bus.mtc0_wdata[31:23] : ctx_base_r;

            if (bus.exc_tlb_valid) begin
                ctx_badvpn2_r <= bus.exc_vaddr[31:13];
                badvaddr_r    <= bus.exc_vaddr;
            end else begin
                ctx_badvpn2_r <= ctx_badvpn2_r;
                badvaddr_r    <= badvaddr_r;
            end
        end
    end

`ifdef CP0_TLB_ASID_EN
    // ASID is untouched by exceptions; only TLBR and mtc0 update it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asid_r <= 8'd0;
        end else if (tlbr_cap_s) begin
            asid_r <= in_tlb_config[7:0];
        end else if (wr_hi_s) begin
            asid_r <= bus.mtc0_wdata[7:0];
        end else begin
            asid_r <= asid_r;
        end
    end

    assign entry_hi_s = {hi_vpn2_r, 5'd0, asid_r};
`else
    assign entry_hi_s = {hi_vpn2_r, 13'd0};
`endif

    // Combinational CP0 read port
    always_comb begin
        rdata_s = 32'd0;
        case (bus.cp0_addr)
            5'd0:    rdata_s = {index_p_r, {(31-Entry_id_width){1'b0}}, index_r};
            5'd1:    rdata_s = {{(32-Entry_id_width){1'b0}}, random_r};
            5'd2:    rdata_s = {2'd0, lo0_r};
            5'd3:    rdata_s = {2'd0, lo1_r};
            5'd4:    rdata_s = {ctx_base_r, ctx_badvpn2_r, 4'd0};
            5'd6:    rdata_s = {{(32-Entry_id_width){1'b0}}, wired_r};
            5'd8:    rdata_s = badvaddr_r;
            5'd10:   rdata_s = entry_hi_s;
            default: rdata_s = 32'd0;
        endcase
    end

    assign bus.mfc0_rdata = rdata_s;

    // Configuration bus toward the MMU; unassigned bits stay zero
    always_comb begin
        out_tlb_config                        = '0;
        out_tlb_config[31:0]                  = entry_hi_s;
        out_tlb_config[63:32]                 = {2'd0, lo0_r};
        out_tlb_config[95:64]                 = {2'd0, lo1_r};
        out_tlb_config[96 +: Entry_id_width]  = index_r;
        out_tlb_config[102 +: Entry_id_width] = random_r;
    end

    assign unused_s = ^{in_tlb_config, bus.mtc0_wdata, bus.exc_vaddr};

endmodule

// File: doc/cp0_tlb_regs.md
Name: cp0_tlb_regs

Overview:
CP0-side owner of the TLB management registers: EntryHi, EntryLo0, EntryLo1, Index, Random, Wired, Context and BadVAddr. It packs these into the configuration bus consumed by the MMU and sequences TLBR/TLBWI/TLBWR/TLBP through a small FSM that drives op_type. It captures TLBR/TLBP results from the MMU's returned configuration bus and latches faulting addresses on TLB exceptions. It sits between the pipeline's CP0 access path and the MMU.

Parameters:
TLB_entry_num, 16, number of TLB lines
Entry_id_width, 4, index width (log2 TLB_entry_num)
in_tlb_config_width, 160, width of bus returned from MMU
out_tlb_config_width, 142, width of bus driven to MMU

Ports:
clk  in  1  single clock
rst  in  1  asynchronous active-low reset
mtc0_we  in  1  CP0 register write strobe
cp0_addr  in  5  register number: 0 Index, 1 Random, 2 EntryLo0, 3 EntryLo1, 4 Context, 6 Wired, 8 BadVAddr, 10 EntryHi
mtc0_wdata  in  32  write data
mfc0_rdata  out  32  combinational read of cp0_addr; unlisted addresses read 0
tlb_req  in  1  TLB instruction request, sampled in IDLE only
tlb_op  in  3  001 TLBR, 010 TLBWI, 011 TLBWR, 100 TLBP
tlb_busy  out  1  high while FSM not IDLE; pipeline stalls on it
tlb_done  out  1  one-cycle pulse when operation retires
exc_tlb_valid  in  1  TLB refill/invalid/modify exception this cycle
exc_vaddr  in  32  faulting virtual address
tlbp_hit  in  1  OR of MMU per-line probe hits
in_tlb_config  in  in_tlb_config_width  from MMU: [31:0] EntryHi, [63:32] EntryLo0, [95:64] EntryLo1, [127:96] Index; [159:128] ignored
out_tlb_config  out  out_tlb_config_width  to MMU: [31:0] EntryHi, [63:32] EntryLo0, [95:64] EntryLo1, [95+Entry_id_width:96] Index, [101+Entry_id_width:102] Random; other bits 0
op_type  out  3  to MMU; nonzero only in ISSUE

Behaviour:
- Reset (rst=0): all registers 0 except Random = TLB_entry_num-1. FSM IDLE, op_type=0, tlb_busy=0, tlb_done=0.
- Writable masks:
  - EntryHi bits 31:13 and 7:0.
  - EntryLo0/1 bits 29:0.
  - Index bits Entry_id_width-1:0. Index bit 31 (P) is read-only and set only by TLBP.
  - Wired bits Entry_id_width-1:0.
  - Context bits 31:23.
  - Random and BadVAddr are read-only; writes to them are ignored.
- A write to Wired also loads Random = TLB_entry_num-1.
- Random:
  - Decrements each cycle while FSM is IDLE and no Wired write occurs.
  - When Random equals Wired it wraps to TLB_entry_num-1 on the next decrement.
  - If Wired >= TLB_entry_num-1, Random holds at TLB_entry_num-1.
  - Frozen outside IDLE, so TLBWR sees a stable value.
- FSM:
  - IDLE: tlb_req=1 with a legal op latches the op and moves to ISSUE. Illegal ops are dropped with no done pulse.
  - ISSUE (1 cycle): op_type = latched op. At the clock edge:
    - TLBR loads EntryHi/EntryLo0/EntryLo1 from in_tlb_config, with write masks applied.
    - TLBP loads Index = {~tlbp_hit, zeros, in_tlb_config[95+Entry_id_width:96]}. Index[Entry_id_width-1:0] is loaded only on a hit and is unchanged on a miss.
    - Next state is DONE.
  - DONE (1 cycle): tlb_done=1, op_type=0. Next state is IDLE.
- Latency: request edge to tlb_done is 2 cycles. tlb_busy is high in ISSUE and DONE.
- mtc0_we while tlb_busy=1 is ignored. The pipeline guarantees this does not occur.
- Exceptions (any state), on exc_tlb_valid:
  - BadVAddr = exc_vaddr.
  - EntryHi[31:13] = exc_vaddr[31:13]; ASID unchanged.
  - Context[22:4] = exc_vaddr[31:13].
- Simultaneous events:
  - Exception vs mtc0 in the same cycle: the exception wins for the fields it touches; mtc0 still writes its other bits.
  - Exception vs TLBR capture of EntryHi: the exception wins.
- Reset mid-operation returns to IDLE immediately. No done pulse, no capture.

Optional Feature:
CP0_TLB_ASID_EN:
- Defined: EntryHi[7:0] (ASID) is stored, read back and forwarded on out_tlb_config.
- Undefined: no ASID storage. EntryHi[7:0] reads 0 and is driven 0 to the MMU. TLBR capture of those bits is discarded.

Test Plan:
- Reset, idle 3 cycles -> Random reads 15,14,13. Write Wired=14 -> Random=15 next cycle, then 14, then 15 (wrap).
- mtc0 EntryHi=0xFFFFFFFF -> reads 0xFFFFE0FF (ASID_EN) / 0xFFFFE000 (no ASID). mtc0 Index=0xFFFFFFFF -> reads 0x0000000F.
- tlb_req TLBWI with Index=5 -> op_type=010 for exactly the cycle after request, out_tlb_config[99:96]=5, tlb_done 2 cycles after request, Random frozen while busy.
- TLBP with tlbp_hit=1, in_tlb_config[99:96]=9 -> Index reads 0x00000009. TLBP with tlbp_hit=0 -> Index reads 0x80000009 (low bits retained).
- TLBR with in_tlb_config Hi=0x12346055, Lo0=0xC0000047 -> EntryHi=0x12346055 (ASID_EN), EntryLo0=0x00000047.
- exc_tlb_valid with exc_vaddr=0xABCDE123, same cycle as mtc0 EntryHi=0x000000AA -> BadVAddr=0xABCDE123, EntryHi=0xABCDE0AA, Context[22:4]=0x55E6F. Assert rst during ISSUE -> op_type=0 and FSM IDLE with no done pulse.
